// File: rtl/secuenciador_pkg.sv
// Shared definitions for the counter sequencer.
//  - Counter mode encodings driven on MODO.
//  - Sequencer FSM state type.
// No ports.
package secuenciador_pkg;

  localparam logic [1:0] MODO_ARRIBA = 2'b00;  // count up by 1
  localparam logic [1:0] MODO_ABAJO  = 2'b01;  // count down by 1
  localparam logic [1:0] MODO_ABAJO3 = 2'b10;  // count down by 3
  localparam logic [1:0] MODO_CARGA  = 2'b11;  // parallel load from D

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    DRAIN,
    FIN
  } estado_t;

endpackage

// File: rtl/secuenciador_contador_if.sv
// Command/result bundle between a command source and the sequencer.
// Parameters: WIDTH (data), CW (cycle count), RCW (wrap counter).
// Signals:
//  req_valid/req_ready   command handshake
//  req_modo/valor/ciclos command payload
//  abort                 end the RUN phase early
//  done                  one-cycle result pulse
//  resultado/rco_cnt     final counter value and wrap count
//  abortado              command ended by abort
// Modports: master = command source, slave = sequencer.
interface secuenciador_contador_if #(
  parameter int WIDTH = 4,
  parameter int CW    = 8,
  parameter int RCW   = 8
);

  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_modo;
  logic [WIDTH-1:0] req_valor;
  logic [CW-1:0]    req_ciclos;
  logic             abort;
  logic             done;
  logic [WIDTH-1:0] resultado;
  logic [RCW-1:0]   rco_cnt;
  logic             abortado;

  modport master (
    output req_valid, req_modo, req_valor, req_ciclos, abort,
    input  req_ready, done, resultado, rco_cnt, abortado
  );

  modport slave (
    input  req_valid, req_modo, req_valor, req_ciclos, abort,
    output req_ready, done, resultado, rco_cnt, abortado
  );

endinterface

// File: rtl/modelo_contador.sv
// Reference model of the mode counter, driven from the same ENB/MODO/D
// the sequencer sends to the real counter.
// Ports:
//  CLK, RESET   clock, synchronous active-high reset
//  enb          count enable
//  modo         00 +1, 01 -1, 10 -3 (mod 2^WIDTH), 11 load d
//  d            load data
//  q            modelled counter value (registered)
//  rco          modelled wrap flag, high the cycle after a wrapping edge
// Assumes WIDTH >= 2 so that the -3 step is meaningful.
module modelo_contador
  import secuenciador_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             enb,
  input  logic [1:0]       modo,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             rco
);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      q   <= '0;
      rco <= 1'b0;
    end else if (enb) begin
      case (modo)
        MODO_ARRIBA: begin
          q   <= q + WIDTH'(1);
          rco <= &q;
        end
        MODO_ABAJO: begin
          q   <= q - WIDTH'(1);
          rco <= (q == '0);
        end
        MODO_ABAJO3: begin
          q   <= q - WIDTH'(3);
          rco <= (q < WIDTH'(3));
        end
        default: begin
          q   <= d;
          rco <= 1'b0;
        end
      endcase
    end else begin
      rco <= 1'b0;
    end
  end

endmodule

// File: rtl/secuenciador_contador.sv
// Command sequencer for the mode counter.
// Accepts one command (start value, run mode, cycle count) per handshake,
// loads the counter, runs it for the requested number of cycles (or until
// abort), lets the last edge settle, then reports Q and the RCO wrap count.
// FSM: IDLE -> LOAD -> RUN -> DRAIN -> FIN -> IDLE (RUN skipped when ciclos=0).
// Ports:
//  CLK, RESET   clock, synchronous active-high reset
//  cmd          command/result bundle (slave side)
//  ENB/MODO/D   counter controls (registered)
//  Q/RCO        counter outputs
//  err          sticky mismatch against the internal counter model
// Build option: SECUENCIADOR_CHEQUEO_EN instantiates modelo_contador and
// drives err; without it err is tied low.
module secuenciador_contador
  import secuenciador_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CW    = 8,
  parameter int RCW   = 8
) (
  input  logic                      CLK,
  input  logic                      RESET,
  secuenciador_contador_if.slave    cmd,
  output logic                      ENB,
  output logic [1:0]                MODO,
  output logic [WIDTH-1:0]          D,
  input  logic [WIDTH-1:0]          Q,
  input  logic                      RCO,
  output logic                      err
);

  estado_t          state_reg;
  logic [1:0]       modo_reg;
  logic [WIDTH-1:0] valor_reg;
  logic [CW-1:0]    rem_reg;
  logic             enb_reg;
  logic [1:0]       modo_out_reg;
  logic [WIDTH-1:0] d_reg;
  logic             ready_reg;
  logic             done_reg;
  logic [WIDTH-1:0] resultado_reg;
  logic [RCW-1:0]   rco_cnt_reg;
  logic             abortado_reg;
  logic             rco_inc;

  // RCO reflects the edge of the previous cycle, so sampling it in RUN and
  // DRAIN covers exactly the edges taken in RUN (the LOAD edge yields 0).
  assign rco_inc = ((state_reg == RUN) || (state_reg == DRAIN)) && RCO && !(&rco_cnt_reg);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg     <= IDLE;
      modo_reg      <= MODO_ARRIBA;
      valor_reg     <= '0;
      rem_reg       <= '0;
      enb_reg       <= 1'b0;
      modo_out_reg  <= MODO_CARGA;
      d_reg         <= '0;
      ready_reg     <= 1'b1;
      done_reg      <= 1'b0;
      resultado_reg <= '0;
      rco_cnt_reg   <= '0;
      abortado_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (rco_inc) begin
        rco_cnt_reg <= rco_cnt_reg + RCW'(1);
      end
      case (state_reg)
        IDLE: begin
          if (cmd.req_valid) begin
            modo_reg     <= cmd.req_modo;
            valor_reg    <= cmd.req_valor;
            rem_reg      <= cmd.req_ciclos;
            rco_cnt_reg  <= '0;
            abortado_reg <= 1'b0;
            ready_reg    <= 1'b0;
            enb_reg      <= 1'b1;
            modo_out_reg <= MODO_CARGA;
            d_reg        <= cmd.req_valor;
            state_reg    <= LOAD;
          end
        end
        LOAD: begin
          // Both RUN and DRAIN present the run mode; only ENB differs.
          modo_out_reg <= modo_reg;
          d_reg        <= valor_reg;
          if (rem_reg != '0) begin
            state_reg <= RUN;
          end else begin
            enb_reg   <= 1'b0;
            state_reg <= DRAIN;
          end
        end
        RUN: begin
          rem_reg <= rem_reg - CW'(1);
          // The last cycle wins over abort: the command completed normally.
          if (rem_reg == CW'(1)) begin
            enb_reg   <= 1'b0;
            state_reg <= DRAIN;
          end else if (cmd.abort) begin
            enb_reg      <= 1'b0;
            abortado_reg <= 1'b1;
            state_reg    <= DRAIN;
          end
        end
        DRAIN: begin
          done_reg      <= 1'b1;
          resultado_reg <= Q;
          modo_out_reg  <= MODO_CARGA;
          state_reg     <= FIN;
        end
        FIN: begin
          ready_reg <= 1'b1;
          state_reg <= IDLE;
        end
        default: begin
          enb_reg   <= 1'b0;
          ready_reg <= 1'b1;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign ENB           = enb_reg;
  assign MODO          = modo_out_reg;
  assign D             = d_reg;
  assign cmd.req_ready = ready_reg;
  assign cmd.done      = done_reg;
  assign cmd.resultado = resultado_reg;
  assign cmd.rco_cnt   = rco_cnt_reg;
  assign cmd.abortado  = abortado_reg;

`ifdef SECUENCIADOR_CHEQUEO_EN
  logic [WIDTH-1:0] q_modelo;
  logic             rco_modelo;
  logic             ventana;
  logic             err_reg;

  modelo_contador #(.WIDTH(WIDTH)) u_modelo (
    .CLK   (CLK),
    .RESET (RESET),
    .enb   (enb_reg),
    .modo  (modo_out_reg),
    .d     (d_reg),
    .q     (q_modelo),
    .rco   (rco_modelo)
  );

  // Model and counter agree only once the LOAD edge has been taken.
  assign ventana = (state_reg == RUN) || (state_reg == DRAIN) || (state_reg == FIN);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      err_reg <= 1'b0;
    end else if (ventana && ((Q != q_modelo) || (RCO != rco_modelo))) begin
      err_reg <= 1'b1;
    end
  end

  assign err = err_reg;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_secuenciador_contador.sv
// Directed bench for secuenciador_contador with WIDTH=4, including a
// behavioural 4-bit mode counter and a mux that can override its Q.
module tb_secuenciador_contador;
  import secuenciador_pkg::*;

  localparam int WIDTH = 4;
  localparam int CW    = 8;
  localparam int RCW   = 8;

  logic             CLK = 1'b0;
  logic             RESET;
  logic             ENB;
  logic [1:0]       MODO;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Q;
  logic             RCO;
  logic             err;

  logic [WIDTH-1:0] cnt_q;
  logic             cnt_rco;
  logic [WIDTH:0]   cnt_ext;
  logic             force_en;
  logic [WIDTH-1:0] force_val;
  logic             exp_err;

  int vectors    = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  secuenciador_contador_if #(.WIDTH(WIDTH), .CW(CW), .RCW(RCW)) cmd_if ();

  secuenciador_contador #(.WIDTH(WIDTH), .CW(CW), .RCW(RCW)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .cmd   (cmd_if),
    .ENB   (ENB),
    .MODO  (MODO),
    .D     (D),
    .Q     (Q),
    .RCO   (RCO),
    .err   (err)
  );

  // Counter under control: carry/borrow taken from a 5-bit result.
  always_comb begin
    cnt_ext = '0;
    case (MODO)
      2'b00:   cnt_ext = {1'b0, cnt_q} + 5'd1;
      2'b01:   cnt_ext = {1'b0, cnt_q} - 5'd1;
      2'b10:   cnt_ext = {1'b0, cnt_q} - 5'd3;
      default: cnt_ext = {1'b0, D};
    endcase
  end

  always @(posedge CLK) begin
    if (RESET) begin
      cnt_q   <= '0;
      cnt_rco <= 1'b0;
    end else if (ENB) begin
      cnt_q   <= cnt_ext[WIDTH-1:0];
      cnt_rco <= cnt_ext[WIDTH];
    end else begin
      cnt_rco <= 1'b0;
    end
  end

  assign Q   = force_en ? force_val : cnt_q;
  assign RCO = cnt_rco;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Issue one command and follow it to done. Cycle 0 is the accept cycle,
  // LOAD is cycle 1, RUN cycle k is cycle 1+k. abort_at/force_at select a
  // RUN cycle (0 = never) for abort or for overriding Q with force_val.
  task automatic run_cmd(input string tag, input logic [3:0] valor, input logic [1:0] modo,
                         input logic [7:0] ciclos, input int abort_at, input int force_at,
                         input logic [3:0] exp_res, input logic [7:0] exp_rco, input logic exp_ab);
    int c;
    int eff;
    int enb_cycles;
    int wait_n;
    eff = (abort_at != 0) ? abort_at : int'(ciclos);
    @(negedge CLK);
    cmd_if.req_valid  = 1'b1;
    cmd_if.req_modo   = modo;
    cmd_if.req_valor  = valor;
    cmd_if.req_ciclos = ciclos;
    wait_n = 0;
    while (!cmd_if.req_ready && wait_n < 200) begin
      @(negedge CLK);
      wait_n++;
    end
    check({tag, " ready"}, 32'(cmd_if.req_ready), 32'd1);
    @(negedge CLK);
    cmd_if.req_valid = 1'b0;
    c = 1;
    enb_cycles = 0;
    while (!cmd_if.done && c < 300) begin
      if (ENB) enb_cycles++;
      cmd_if.abort = (abort_at != 0) && (c == abort_at + 1);
      force_en     = (force_at != 0) && (c == force_at + 1);
      @(negedge CLK);
      c++;
    end
    cmd_if.abort = 1'b0;
    force_en     = 1'b0;
    check({tag, " latency"},   32'(c), 32'(eff + 3));
    check({tag, " enb_cyc"},   32'(enb_cycles), 32'(eff + 1));
    check({tag, " resultado"}, 32'(cmd_if.resultado), 32'(exp_res));
    check({tag, " rco_cnt"},   32'(cmd_if.rco_cnt), 32'(exp_rco));
    check({tag, " abortado"},  32'(cmd_if.abortado), 32'(exp_ab));
    check({tag, " err"},       32'(err), 32'(exp_err));
    $display("cmd %s valor=%0d modo=%0d ciclos=%0d -> resultado=%0d rco_cnt=%0d abortado=%0d latency=%0d",
             tag, valor, modo, ciclos, cmd_if.resultado, cmd_if.rco_cnt, cmd_if.abortado, c);
  endtask

  initial begin
    int acc;
    int done_n;
    int done_cyc1;
    int acc_cyc2;
    int wait_n;

    RESET             = 1'b1;
    cmd_if.req_valid  = 1'b0;
    cmd_if.req_modo   = MODO_ARRIBA;
    cmd_if.req_valor  = '0;
    cmd_if.req_ciclos = '0;
    cmd_if.abort      = 1'b0;
    force_en          = 1'b0;
    force_val         = 4'hA;
    exp_err           = 1'b0;
    repeat (3) @(negedge CLK);
    RESET = 1'b0;

    check("rst ENB",       32'(ENB), 32'd0);
    check("rst MODO",      32'(MODO), 32'd3);
    check("rst D",         32'(D), 32'd0);
    check("rst ready",     32'(cmd_if.req_ready), 32'd1);
    check("rst done",      32'(cmd_if.done), 32'd0);
    check("rst resultado", 32'(cmd_if.resultado), 32'd0);
    check("rst rco_cnt",   32'(cmd_if.rco_cnt), 32'd0);
    check("rst abortado",  32'(cmd_if.abortado), 32'd0);
    check("rst err",       32'(err), 32'd0);

    //      tag     valor  modo         ciclos ab  frc res    rco   ab
    run_cmd("up16",  4'd0,  MODO_ARRIBA, 8'd16, 0,  0,  4'd0,  8'd1, 1'b0);
    run_cmd("dn16",  4'd15, MODO_ABAJO,  8'd16, 0,  0,  4'd15, 8'd1, 1'b0);
    run_cmd("dn3x3", 4'd0,  MODO_ABAJO3, 8'd3,  0,  0,  4'd7,  8'd1, 1'b0);
    run_cmd("load0", 4'd9,  MODO_ARRIBA, 8'd0,  0,  0,  4'd9,  8'd0, 1'b0);
    run_cmd("abrt5", 4'd0,  MODO_ARRIBA, 8'd40, 5,  0,  4'd5,  8'd0, 1'b1);
    run_cmd("abrtL", 4'd0,  MODO_ARRIBA, 8'd40, 40, 0,  4'd8,  8'd2, 1'b0);
    run_cmd("rld4",  4'd6,  MODO_CARGA,  8'd4,  0,  0,  4'd6,  8'd0, 1'b0);

    // req_valid held across a busy command: A = 3 up x4, then B = 10 down x2.
    @(negedge CLK);
    cmd_if.req_valid  = 1'b1;
    cmd_if.req_modo   = MODO_ARRIBA;
    cmd_if.req_valor  = 4'd3;
    cmd_if.req_ciclos = 8'd4;
    acc = 0;
    done_n = 0;
    done_cyc1 = -1;
    acc_cyc2 = -1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (cmd_if.done) begin
        done_n++;
        if (done_n == 1) done_cyc1 = cyc;
      end
      if (cmd_if.req_ready && cmd_if.req_valid) begin
        acc++;
        if (acc == 2) acc_cyc2 = cyc;
      end
      if (acc == 1 && !cmd_if.req_ready) begin
        cmd_if.req_modo   = MODO_ABAJO;
        cmd_if.req_valor  = 4'd10;
        cmd_if.req_ciclos = 8'd2;
      end
      if (acc == 2 && !cmd_if.req_ready) cmd_if.req_valid = 1'b0;
      @(negedge CLK);
    end
    cmd_if.req_valid = 1'b0;
    check("held accepts",   32'(acc), 32'd2);
    check("held dones",     32'(done_n), 32'd2);
    check("held done1 cyc", 32'(done_cyc1), 32'd7);
    check("held acc2 cyc",  32'(acc_cyc2), 32'd8);
    check("held resultado", 32'(cmd_if.resultado), 32'd8);
    $display("cmd held-valid accepts=%0d dones=%0d done1=%0d acc2=%0d resultado=%0d",
             acc, done_n, done_cyc1, acc_cyc2, cmd_if.resultado);

    // Q overridden for one RUN cycle; with the model built in, err latches.
    run_cmd("force", 4'd0, MODO_ARRIBA, 8'd6, 0, 3, 4'd6, 8'd0, 1'b0);
`ifdef SECUENCIADOR_CHEQUEO_EN
    exp_err = 1'b1;
`endif
    check("force err", 32'(err), 32'(exp_err));
    run_cmd("after", 4'd2, MODO_ABAJO, 8'd3, 0, 0, 4'd15, 8'd1, 1'b0);

    // Reset in the middle of RUN.
    @(negedge CLK);
    cmd_if.req_valid  = 1'b1;
    cmd_if.req_modo   = MODO_ARRIBA;
    cmd_if.req_valor  = 4'd0;
    cmd_if.req_ciclos = 8'd20;
    wait_n = 0;
    while (!cmd_if.req_ready && wait_n < 200) begin
      @(negedge CLK);
      wait_n++;
    end
    @(negedge CLK);
    cmd_if.req_valid = 1'b0;
    repeat (4) @(negedge CLK);
    check("mid ENB", 32'(ENB), 32'd1);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    exp_err = 1'b0;
    check("mrst ENB",       32'(ENB), 32'd0);
    check("mrst MODO",      32'(MODO), 32'd3);
    check("mrst ready",     32'(cmd_if.req_ready), 32'd1);
    check("mrst done",      32'(cmd_if.done), 32'd0);
    check("mrst resultado", 32'(cmd_if.resultado), 32'd0);
    check("mrst err",       32'(err), 32'd0);
    done_n = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (cmd_if.done) done_n++;
      @(negedge CLK);
    end
    check("mrst no done", 32'(done_n), 32'd0);
    $display("cmd reset-mid-run dones_after=%0d ready=%0d", done_n, cmd_if.req_ready);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
